dualport_fifo_ctrl: RTL and testbench



---
 rtl/dualport_fifo_pkg.sv | 10 +
 rtl/dualport_fifo_ctrl_fifo_ptr.sv | 24 ++
 rtl/dualport_fifo_ctrl.sv | 120 ++++++++++++
 tb/tb_dualport_fifo_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/dualport_fifo_pkg.sv
// Shared defaults for the dual-port RAM FIFO controller.
package dualport_fifo_pkg;

  localparam int DEF_RAM_WIDTH = 8;
  localparam int DEF_ADD_SIZE  = 4;
  localparam int DEF_RAM_DEPTH = 2 ** DEF_ADD_SIZE;
  // Occupancy needs one extra bit so that a full FIFO (count == depth) is representable.
  localparam int DEF_CNT_W     = DEF_ADD_SIZE + 1;

endpackage

// File: rtl/dualport_fifo_ctrl_fifo_ptr.sv
// Wrapping RAM address pointer with synchronous reset and increment enable.
module fifo_ptr #(
  parameter int ADD_SIZE = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_inc,
  output logic [ADD_SIZE-1:0] o_ptr
);

  logic [ADD_SIZE-1:0] r_ptr;

  // Advance by one per enabled cycle; wraps at depth-1 via natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + 1'b1;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/dualport_fifo_ctrl.sv
// FIFO controller driving the write/read ports of an external synchronous
// dual-port RAM. Optional sticky overflow/underflow flags are built when
// FIFO_OVERFLOW_FLAG_EN is defined; otherwise both flags read 0.
module dualport_fifo_ctrl
  import dualport_fifo_pkg::*;
#(
  parameter int RAM_WIDTH = DEF_RAM_WIDTH,
  parameter int RAM_DEPTH = DEF_RAM_DEPTH,
  parameter int ADD_SIZE  = DEF_ADD_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_push,
  input  logic [RAM_WIDTH-1:0] i_push_data,
  input  logic                 i_pop,
  output logic [RAM_WIDTH-1:0] o_pop_data,
  output logic                 o_pop_valid,
  output logic                 o_full,
  output logic                 o_empty,
  output logic [ADD_SIZE:0]    o_count,
  output logic                 o_overflow,
  output logic                 o_underflow,
  output logic                 o_write,
  output logic [ADD_SIZE-1:0]  o_write_add,
  output logic [RAM_WIDTH-1:0] o_data_in,
  output logic                 o_read,
  output logic [ADD_SIZE-1:0]  o_read_add,
  input  logic [RAM_WIDTH-1:0] i_data_out
);

  localparam int              CNT_W   = ADD_SIZE + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAM_DEPTH);

  logic [CNT_W-1:0]    r_count;
  logic                r_pop_valid;
  logic                w_full;
  logic                w_empty;
  logic                w_push_acc;
  logic                w_pop_acc;
  logic [ADD_SIZE-1:0] w_wr_ptr;
  logic [ADD_SIZE-1:0] w_rd_ptr;

  // Accept decisions use only the registered count, so a push into a full
  // FIFO is refused even if a pop frees a slot in the same cycle (and vice
  // versa); this keeps read and write addresses distinct in any one cycle.
  assign w_full     = (r_count == DEPTH_C);
  assign w_empty    = (r_count == '0);
  assign w_push_acc = i_push & ~w_full;
  assign w_pop_acc  = i_pop & ~w_empty;

  fifo_ptr #(.ADD_SIZE(ADD_SIZE)) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_push_acc),
    .o_ptr (w_wr_ptr)
  );

  fifo_ptr #(.ADD_SIZE(ADD_SIZE)) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_pop_acc),
    .o_ptr (w_rd_ptr)
  );

  // Occupancy tracking; simultaneous accepted push and pop cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      case ({w_push_acc, w_pop_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Read data strobe lines up with the RAM's one-cycle registered output.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pop_valid <= 1'b0;
    end else begin
      r_pop_valid <= w_pop_acc;
    end
  end

`ifdef FIFO_OVERFLOW_FLAG_EN
  logic r_overflow;
  logic r_underflow;

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (i_push & w_full) r_overflow <= 1'b1;
      if (i_pop & w_empty) r_underflow <= 1'b1;
    end
  end

  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;
`else
  assign o_overflow  = 1'b0;
  assign o_underflow = 1'b0;
`endif

  assign o_write     = w_push_acc;
  assign o_write_add = w_wr_ptr;
  assign o_data_in   = i_push_data;
  assign o_read      = w_pop_acc;
  assign o_read_add  = w_rd_ptr;
  assign o_pop_data  = i_data_out;
  assign o_pop_valid = r_pop_valid;
  assign o_full      = w_full;
  assign o_empty     = w_empty;
  assign o_count     = r_count;

endmodule

// File: tb/tb_dualport_fifo_ctrl.sv
// Scoreboard bench for dualport_fifo_ctrl with a behavioural RAM attached.
module tb_dualport_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_push = 1'b0;
  logic [7:0] i_push_data = 8'h00;
  logic       i_pop = 1'b0;
  logic [7:0] o_pop_data;
  logic       o_pop_valid;
  logic       o_full;
  logic       o_empty;
  logic [4:0] o_count;
  logic       o_overflow;
  logic       o_underflow;
  logic       o_write;
  logic [3:0] o_write_add;
  logic [7:0] o_data_in;
  logic       o_read;
  logic [3:0] o_read_add;
  logic [7:0] ram_dout = 8'h00;

  logic [7:0] mem [16];

`ifdef FIFO_OVERFLOW_FLAG_EN
  localparam logic FLAG_EN = 1'b1;
`else
  localparam logic FLAG_EN = 1'b0;
`endif

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state
  int         mcnt = 0;
  int         mwp  = 0;
  int         mrp  = 0;
  logic [7:0] model_q [$];
  logic [7:0] sb [$];

  dualport_fifo_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .i_push      (i_push),
    .i_push_data (i_push_data),
    .i_pop       (i_pop),
    .o_pop_data  (o_pop_data),
    .o_pop_valid (o_pop_valid),
    .o_full      (o_full),
    .o_empty     (o_empty),
    .o_count     (o_count),
    .o_overflow  (o_overflow),
    .o_underflow (o_underflow),
    .o_write     (o_write),
    .o_write_add (o_write_add),
    .o_data_in   (o_data_in),
    .o_read      (o_read),
    .o_read_add  (o_read_add),
    .i_data_out  (ram_dout)
  );

  always #5 clk = ~clk;

  // External RAM: registered read, one cycle latency.
  always @(posedge clk) begin
    if (o_write) mem[o_write_add] <= o_data_in;
    if (o_read)  ram_dout <= mem[o_read_add];
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every pop_valid strobe must match the oldest expected word.
  always @(negedge clk) begin
    if (o_pop_valid === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL pop_valid: strobe with data %0h, expected no strobe", o_pop_data);
      end else begin
        logic [7:0] e;
        e = sb.pop_front();
        if (o_pop_data !== e) begin
          n_err++;
          $display("FAIL pop_data: got %0h expected %0h", o_pop_data, e);
        end
      end
    end
  end

  task automatic do_cyc(input logic p, input logic [7:0] d, input logic q);
    logic ew, er;
    @(negedge clk);
    i_push = p; i_push_data = d; i_pop = q;
    #1;
    ew = p && (mcnt != 16);
    er = q && (mcnt != 0);
    check("write", 32'(o_write), 32'(ew));
    check("read", 32'(o_read), 32'(er));
    if (ew) check("write_add", 32'(o_write_add), 32'(mwp));
    if (er) check("read_add", 32'(o_read_add), 32'(mrp));
    if (er) begin
      sb.push_back(model_q.pop_front());
      mrp = (mrp + 1) % 16;
    end
    if (ew) begin
      model_q.push_back(d);
      mwp = (mwp + 1) % 16;
    end
    if (ew && !er) mcnt++;
    if (er && !ew) mcnt--;
    @(posedge clk);
    #1;
    check("count", 32'(o_count), 32'(mcnt));
    check("empty", 32'(o_empty), 32'(mcnt == 0));
    check("full", 32'(o_full), 32'(mcnt == 16));
  endtask

  task automatic reset_dut(input logic q);
    @(negedge clk);
    rst = 1'b1; i_push = 1'b0; i_pop = q;
    @(posedge clk);
    #1;
    check("rst_count", 32'(o_count), 32'd0);
    check("rst_empty", 32'(o_empty), 32'd1);
    check("rst_full", 32'(o_full), 32'd0);
    check("rst_pop_valid", 32'(o_pop_valid), 32'd0);
    check("rst_write_add", 32'(o_write_add), 32'd0);
    check("rst_read_add", 32'(o_read_add), 32'd0);
    check("rst_overflow", 32'(o_overflow), 32'd0);
    check("rst_underflow", 32'(o_underflow), 32'd0);
    @(negedge clk);
    rst = 1'b0; i_pop = 1'b0;
    mcnt = 0; mwp = 0; mrp = 0;
    model_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_dut(1'b0);

    // Idle after reset
    for (int i = 0; i < 3; i++) do_cyc(1'b0, 8'h00, 1'b0);
    check("idle_pop_valid", 32'(o_pop_valid), 32'd0);
    check("idle_write", 32'(o_write), 32'd0);

    // Three pushes then three pops
    do_cyc(1'b1, 8'h11, 1'b0);
    do_cyc(1'b1, 8'h22, 1'b0);
    do_cyc(1'b1, 8'h33, 1'b0);
    check("count_after_3", 32'(o_count), 32'd3);
    for (int i = 0; i < 3; i++) do_cyc(1'b0, 8'h00, 1'b1);
    check("count_after_pop3", 32'(o_count), 32'd0);

    // Fill, overflow attempt, drain
    for (int i = 0; i < 16; i++) do_cyc(1'b1, 8'($urandom_range(0, 255)), 1'b0);
    check("full_at_16", 32'(o_full), 32'd1);
    check("count_at_16", 32'(o_count), 32'd16);
    do_cyc(1'b1, 8'hEE, 1'b0);
    check("overflow", 32'(o_overflow), 32'(FLAG_EN));
    check("count_stays_16", 32'(o_count), 32'd16);
    for (int i = 0; i < 16; i++) do_cyc(1'b0, 8'h00, 1'b1);

    // Pointer wrap from a fresh start
    reset_dut(1'b0);
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 10; i++) do_cyc(1'b1, 8'(8'h40 + b * 16 + i), 1'b0);
      for (int i = 0; i < 10; i++) do_cyc(1'b0, 8'h00, 1'b1);
    end
    check("wrap_empty", 32'(o_empty), 32'd1);
    check("wrap_write_add", 32'(o_write_add), 32'd4);

    // Simultaneous push and pop at count 5, 0 and 16
    for (int i = 0; i < 5; i++) do_cyc(1'b1, 8'(8'hA0 + i), 1'b0);
    do_cyc(1'b1, 8'hA5, 1'b1);
    check("both_at_5", 32'(o_count), 32'd5);
    for (int i = 0; i < 5; i++) do_cyc(1'b0, 8'h00, 1'b1);
    do_cyc(1'b1, 8'hB0, 1'b1);
    check("both_at_0_count", 32'(o_count), 32'd1);
    check("underflow", 32'(o_underflow), 32'(FLAG_EN));
    for (int i = 0; i < 15; i++) do_cyc(1'b1, 8'(8'hC0 + i), 1'b0);
    do_cyc(1'b1, 8'hCF, 1'b1);
    check("both_at_16_count", 32'(o_count), 32'd15);

    // Drain to 7, then reset while popping
    for (int i = 0; i < 8; i++) do_cyc(1'b0, 8'h00, 1'b1);
    check("count_before_rst", 32'(o_count), 32'd7);
    reset_dut(1'b1);

    for (int i = 0; i < 3; i++) do_cyc(1'b0, 8'h00, 1'b0);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
